test_status_monitor: RTL
========================

Name: test_status_monitor

Overview:
- Hardware-side producer of riscv-tests pass/fail status for the soc.
- Snoops the register-file write-back port for the test-protocol registers: x3 (current test number), x26 (test end flag) and x27 (pass flag).
- Latches the final verdict on end-of-test or watchdog timeout.
- On failure, streams the register file out over a valid/ready dump port, so benches and FPGA builds get the report without hierarchical peeks.

Parameters:
- XLEN, 64, register/data width.
- MAX_CYCLES, 100000, watchdog limit in RUN cycles; must be ≥2.
- DUMP_REGS, 31, number of registers dumped (x0..x(DUMP_REGS-1)); range 1..32.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- wb_we  in  1  register-file write enable.
- wb_waddr  in  5  write-back register index.
- wb_wdata  in  XLEN  write-back data.
- rd_addr  out  5  register-file read address (combinational read port).
- rd_data  in  XLEN  register-file read data, valid the same cycle as rd_addr.
- dump_valid  out  1  dump beat valid.
- dump_ready  in  1  consumer accepts beat.
- dump_idx  out  5  register index of current beat.
- dump_data  out  XLEN  register value of current beat.
- done  out  1  verdict final; held until reset.
- pass  out  1  test passed; meaningful when done=1.
- timeout  out  1  watchdog expired before x26 was set.
- fail_testnum  out  32  last value written to x3 (low 32 bits).

Behaviour:
- Reset (rst=0, async): state=RUN; all outputs 0; cycle counter=0, testnum_q=0, pass_flag_q=0, idx=0.
- States: RUN, DUMP_RD, DUMP_OUT, DONE.
- RUN snoop rules apply only when wb_we=1. Writes with wb_waddr=0 are ignored.
  - waddr=3: testnum_q <= wb_wdata[31:0].
  - waddr=27: pass_flag_q <= (wb_wdata==1).
  - waddr=26 with wb_wdata==1: end of test.
    - If pass_flag_q=1: next state DONE with pass=1.
    - Otherwise: next state DUMP_RD with pass=0.
  - waddr=26 with any other value: no effect.
- Only one write occurs per cycle, so the x27 value used for the verdict is always the one registered before the x26 write.
- Watchdog: counter increments every RUN cycle. A cycle in which counter==MAX_CYCLES-1 and no end-of-test write occurs sets timeout=1 and pass=0, next state DUMP_RD. An end-of-test write in that same cycle wins; timeout stays 0.
- fail_testnum continuously reflects testnum_q and freezes when RUN is left.
- After RUN is exited, all wb_* activity is ignored.
- Dump sequence:
  - DUMP_RD (1 cycle): rd_addr=idx; capture rd_data into dump_data and idx into dump_idx; next state DUMP_OUT.
  - DUMP_OUT: dump_valid=1; dump_data and dump_idx are stable until the handshake.
    - On dump_valid&&dump_ready: if idx==DUMP_REGS-1, go to DONE; else idx++ and go to DUMP_RD.
  - Throughput is at most one beat per 2 cycles; dump_ready may stall indefinitely.
  - dump_valid never drops without a handshake.
- rd_addr is 0 outside DUMP_RD.
- DONE: done=1, dump_valid=0. Terminal until reset.
- done rises in the cycle after the end-of-test write (pass path) or after the last dump handshake (fail/timeout path).
- Reset asserted mid-dump aborts immediately, and all outputs return to 0.

Test Plan:
- Pass: write x3=5, x27=1, then x26=1 → next cycle done=1, pass=1, timeout=0, fail_testnum=5, no dump beats.
- Fail dump: write x3=7, x27=0, x26=1; regs preloaded with rN=N*3; dump_ready=1 → 31 beats, dump_idx 0..30, dump_data=3*idx, each beat 2 cycles apart; then done=1, pass=0, fail_testnum=7.
- Backpressure: fail path with dump_ready low for 10 cycles on beat 4 → dump_valid held, dump_idx=4 and dump_data stable throughout; sequence resumes without loss or duplication.
- Protocol edge cases:
  - x26 written with value 2 → no end of test.
  - Write to x0 → ignored.
  - x27=1 then x27=0 before x26=1 → fail.
  - Writes after done → no change to any output.
- Watchdog: MAX_CYCLES=50, no x26 write → timeout=1 at cycle 50, dump follows, done=1, pass=0. A variant with x26=1 exactly at cycle 49 gives timeout=0.
- Async reset: assert rst=0 mid-dump (beat 10) between clock edges → outputs 0 immediately. After release, a new pass sequence completes normally.

Source files
------------

// File: rtl/test_status_monitor.sv
// Snoops the register-file write-back port for the riscv-tests protocol registers,
// latches the pass/fail verdict and streams the register file out on failure.
module test_status_monitor #(
    parameter int unsigned XLEN       = 64,
    parameter int unsigned MAX_CYCLES = 100000,
    parameter int unsigned DUMP_REGS  = 31
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            wb_we,
    input  logic [4:0]      wb_waddr,
    input  logic [XLEN-1:0] wb_wdata,
    output logic [4:0]      rd_addr,
    input  logic [XLEN-1:0] rd_data,
    output logic            dump_valid,
    input  logic            dump_ready,
    output logic [4:0]      dump_idx,
    output logic [XLEN-1:0] dump_data,
    output logic            done,
    output logic            pass,
    output logic            timeout,
    output logic [31:0]     fail_testnum
);

    localparam int unsigned     CNT_W       = $clog2(MAX_CYCLES) + 1;
    localparam logic [CNT_W-1:0] WD_LAST    = CNT_W'(MAX_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [XLEN-1:0] DATA_ONE    = {{(XLEN-1){1'b0}}, 1'b1};
    localparam logic [4:0]      LAST_IDX    = 5'(DUMP_REGS - 1);
    localparam logic [4:0]      REG_ZERO    = 5'd0;
    localparam logic [4:0]      REG_TESTNUM = 5'd3;
    localparam logic [4:0]      REG_END     = 5'd26;
    localparam logic [4:0]      REG_PASS    = 5'd27;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        DUMP_RD  = 2'd1,
        DUMP_OUT = 2'd2,
        DONE     = 2'd3
    } state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [31:0]       testnum_q, testnum_d;
    logic              pass_flag_q, pass_flag_d;
    logic [4:0]        idx_q, idx_d;
    logic              dump_valid_q, dump_valid_d;
    logic [4:0]        dump_idx_q, dump_idx_d;
    logic [XLEN-1:0]   dump_data_q, dump_data_d;
    logic              done_q, done_d;
    logic              pass_q, pass_d;
    logic              timeout_q, timeout_d;

    logic              snoop_s;
    logic              eot_s;
    logic              wd_expire_s;

    // Write-back decode; only meaningful while the test is still running.
    always_comb begin
        snoop_s     = (state_q == RUN) && wb_we && (wb_waddr != REG_ZERO);
        eot_s       = snoop_s && (wb_waddr == REG_END) && (wb_wdata == DATA_ONE);
        wd_expire_s = (cnt_q == WD_LAST);
    end

    // Next-state and next-output computation for the verdict/dump sequencer.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        testnum_d    = testnum_q;
        pass_flag_d  = pass_flag_q;
        idx_d        = idx_q;
        dump_valid_d = dump_valid_q;
        dump_idx_d   = dump_idx_q;
        dump_data_d  = dump_data_q;
        done_d       = done_q;
        pass_d       = pass_q;
        timeout_d    = timeout_q;

        case (state_q)
            RUN: begin
                cnt_d = cnt_q + CNT_ONE;
                if (snoop_s && (wb_waddr == REG_TESTNUM)) begin
                    testnum_d = wb_wdata[31:0];
                end else begin
                    testnum_d = testnum_q;
                end
                if (snoop_s && (wb_waddr == REG_PASS)) begin
                    pass_flag_d = (wb_wdata == DATA_ONE);
                end else begin
                    pass_flag_d = pass_flag_q;
                end
                // An end-of-test write beats a watchdog expiry in the same cycle.
                if (eot_s) begin
                    if (pass_flag_q) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                        pass_d  = 1'b1;
                    end else begin
                        state_d = DUMP_RD;
                        pass_d  = 1'b0;
                    end
                end else if (wd_expire_s) begin
                    state_d   = DUMP_RD;
                    timeout_d = 1'b1;
                    pass_d    = 1'b0;
                end else begin
                    state_d = RUN;
                end
            end
            DUMP_RD: begin
                dump_data_d  = rd_data;
                dump_idx_d   = idx_q;
                dump_valid_d = 1'b1;
                state_d      = DUMP_OUT;
            end
            DUMP_OUT: begin
                if (dump_valid_q && dump_ready) begin
                    dump_valid_d = 1'b0;
                    if (idx_q == LAST_IDX) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else begin
                        idx_d   = idx_q + 5'd1;
                        state_d = DUMP_RD;
                    end
                end else begin
                    state_d = DUMP_OUT;
                end
            end
            DONE: begin
                dump_valid_d = 1'b0;
                state_d      = DONE;
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    // State and output registers; reset aborts any dump in progress.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= RUN;
            cnt_q        <= {CNT_W{1'b0}};
            testnum_q    <= 32'd0;
            pass_flag_q  <= 1'b0;
            idx_q        <= 5'd0;
            dump_valid_q <= 1'b0;
            dump_idx_q   <= 5'd0;
            dump_data_q  <= {XLEN{1'b0}};
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            testnum_q    <= testnum_d;
            pass_flag_q  <= pass_flag_d;
            idx_q        <= idx_d;
            dump_valid_q <= dump_valid_d;
            dump_idx_q   <= dump_idx_d;
            dump_data_q  <= dump_data_d;
            done_q       <= done_d;
            pass_q       <= pass_d;
            timeout_q    <= timeout_d;
        end
    end

    // Register-file read address is only driven while fetching a dump beat.
    always_comb begin
        if (state_q == DUMP_RD) begin
            rd_addr = idx_q;
        end else begin
            rd_addr = 5'd0;
        end
    end

    assign dump_valid   = dump_valid_q;
    assign dump_idx     = dump_idx_q;
    assign dump_data    = dump_data_q;
    assign done         = done_q;
    assign pass         = pass_q;
    assign timeout      = timeout_q;
    assign fail_testnum = testnum_q;

endmodule
